// File: rtl/ppu_vram_port.sv
// CPU-side PPUADDR/PPUDATA port in front of the 2 KB nametable VRAM: address register,
// two-write latch, nametable mirroring, buffered reads and auto-increment.
module ppu_vram_port (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        cpu_en_in,
    input  logic        cpu_r_nw_in,
    input  logic        cpu_sel_in,
    input  logic [7:0]  cpu_d_in,
    output logic [7:0]  cpu_d_out,
    input  logic        latch_clr_in,
    input  logic        inc32_in,
    input  logic        mirror_v_in,
    output logic        busy_out,
    output logic        vram_en_out,
    output logic        vram_r_nw_out,
    output logic [10:0] vram_a_out,
    output logic [7:0]  vram_d_out,
    input  logic [7:0]  vram_d_in
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR      = 2'd1,
        ST_RD_ADDR = 2'd2,
        ST_RD_CAP  = 2'd3
    } state_t;

    function automatic logic [10:0] map_vram_addr(input logic [13:0] v, input logic mirror_v);
        logic [10:0] a;
        if (mirror_v) begin
            a = {v[10], v[9:0]};
        end else begin
            a = {v[11], v[9:0]};
        end
        return a;
    endfunction

    // 0x2000..0x3EFF: bit 13 set and not in the 0x3F00 palette page
    function automatic logic in_nametable(input logic [13:0] v);
        return v[13] && (v[12:8] != 5'h1F);
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [13:0] v_r;
    logic [13:0] v_nxt_s;
    logic        w_r;
    logic        w_nxt_s;
    logic        w_eff_s;
    logic [7:0]  rbuf_r;
    logic [7:0]  rbuf_nxt_s;
    logic [7:0]  cpu_d_r;
    logic [7:0]  cpu_d_nxt_s;
    logic [10:0] tgt_a_r;
    logic [10:0] tgt_a_nxt_s;
    logic        tgt_ok_r;
    logic        tgt_ok_nxt_s;
    logic [7:0]  wdata_r;
    logic [7:0]  wdata_nxt_s;
    logic        inc32_r;
    logic        inc32_nxt_s;
    logic [13:0] step_s;
    logic        accept_s;

    logic        vram_en_r;
    logic        vram_en_s;
    logic        vram_r_nw_r;
    logic        vram_r_nw_s;
    logic [10:0] vram_a_r;
    logic [10:0] vram_a_s;
    logic [7:0]  vram_d_r;
    logic [7:0]  vram_d_s;
    logic        busy_r;
    logic        busy_s;

    assign accept_s = cpu_en_in && (state_r == ST_IDLE);
    assign step_s   = inc32_r ? 14'd32 : 14'd1;
    assign w_eff_s  = latch_clr_in ? 1'b0 : w_r;

    // State register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state: PPUDATA strobes start an access, which then runs to completion
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && cpu_sel_in) begin
                    state_nxt_s = cpu_r_nw_in ? ST_RD_ADDR : ST_WR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WR:      state_nxt_s = ST_IDLE;
            ST_RD_ADDR: state_nxt_s = ST_RD_CAP;
            ST_RD_CAP:  state_nxt_s = ST_IDLE;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // Datapath next values: address register, latch, read buffer and access target
    always_comb begin
        v_nxt_s      = v_r;
        w_nxt_s      = w_eff_s;
        rbuf_nxt_s   = rbuf_r;
        cpu_d_nxt_s  = cpu_d_r;
        tgt_a_nxt_s  = tgt_a_r;
        tgt_ok_nxt_s = tgt_ok_r;
        wdata_nxt_s  = wdata_r;
        inc32_nxt_s  = inc32_r;
        if (accept_s && !cpu_sel_in && !cpu_r_nw_in) begin
            if (!w_eff_s) begin
                v_nxt_s = {cpu_d_in[5:0], v_r[7:0]};
                w_nxt_s = 1'b1;
            end else begin
                v_nxt_s = {v_r[13:8], cpu_d_in};
                w_nxt_s = 1'b0;
            end
        end else if (accept_s && cpu_sel_in) begin
            // Target is frozen here so mirroring changes mid-access are harmless
            tgt_a_nxt_s  = map_vram_addr(v_r, mirror_v_in);
            tgt_ok_nxt_s = in_nametable(v_r);
            wdata_nxt_s  = cpu_d_in;
            inc32_nxt_s  = inc32_in;
            if (cpu_r_nw_in) begin
                cpu_d_nxt_s = rbuf_r;
            end else begin
                cpu_d_nxt_s = cpu_d_r;
            end
        end else if (state_r == ST_WR) begin
            v_nxt_s = v_r + step_s;
        end else if (state_r == ST_RD_CAP) begin
            v_nxt_s    = v_r + step_s;
            rbuf_nxt_s = tgt_ok_r ? vram_d_in : 8'h00;
        end else begin
            v_nxt_s = v_r;
        end
    end

    // Datapath registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            v_r      <= 14'h0000;
            w_r      <= 1'b0;
            rbuf_r   <= 8'h00;
            cpu_d_r  <= 8'h00;
            tgt_a_r  <= 11'h000;
            tgt_ok_r <= 1'b0;
            wdata_r  <= 8'h00;
            inc32_r  <= 1'b0;
        end else begin
            v_r      <= v_nxt_s;
            w_r      <= w_nxt_s;
            rbuf_r   <= rbuf_nxt_s;
            cpu_d_r  <= cpu_d_nxt_s;
            tgt_a_r  <= tgt_a_nxt_s;
            tgt_ok_r <= tgt_ok_nxt_s;
            wdata_r  <= wdata_nxt_s;
            inc32_r  <= inc32_nxt_s;
        end
    end

    // Outputs decoded from the next state so they can be registered without extra latency
    always_comb begin
        vram_en_s   = 1'b0;
        vram_r_nw_s = 1'b1;
        vram_a_s    = 11'h000;
        vram_d_s    = 8'h00;
        busy_s      = 1'b0;
        case (state_nxt_s)
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            ST_WR: begin
                busy_s = 1'b1;
                if (tgt_ok_nxt_s) begin
                    vram_en_s   = 1'b1;
                    vram_r_nw_s = 1'b0;
                    vram_a_s    = tgt_a_nxt_s;
                    vram_d_s    = wdata_nxt_s;
                end else begin
                    vram_en_s   = 1'b0;
                end
            end
            ST_RD_ADDR, ST_RD_CAP: begin
                busy_s = 1'b1;
                if (tgt_ok_nxt_s) begin
                    vram_en_s = 1'b1;
                    vram_a_s  = tgt_a_nxt_s;
                end else begin
                    vram_en_s = 1'b0;
                end
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vram_en_r   <= 1'b0;
            vram_r_nw_r <= 1'b1;
            vram_a_r    <= 11'h000;
            vram_d_r    <= 8'h00;
            busy_r      <= 1'b0;
        end else begin
            vram_en_r   <= vram_en_s;
            vram_r_nw_r <= vram_r_nw_s;
            vram_a_r    <= vram_a_s;
            vram_d_r    <= vram_d_s;
            busy_r      <= busy_s;
        end
    end

    assign cpu_d_out     = cpu_d_r;
    assign busy_out      = busy_r;
    assign vram_en_out   = vram_en_r;
    assign vram_r_nw_out = vram_r_nw_r;
    assign vram_a_out    = vram_a_r;
    assign vram_d_out    = vram_d_r;

endmodule
